// File: rtl/muldiv_unit.sv
// muldiv_unit -- multi-cycle integer multiply/divide unit with HI/LO registers.
//
// Sits beside the EX-stage ALU of the pipelined core. MULT/MULTU/DIV/DIVU run
// for WIDTH step cycles plus one finish cycle. MTHI/MTLO write HI/LO directly.
//
// Handshake: start is sampled on a rising clk edge only while busy=0. A
// MULT/DIV request then raises busy for WIDTH+1 cycles. In the following
// cycle, done pulses for exactly one cycle, busy is low, and hi/lo hold the
// new result, so a new start can be accepted in that cycle. flush aborts a
// request in flight; it also drops a start presented in the same cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request strobe
//   op         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//   a, b       rs / rt operands
//   flush      squash in-flight MULT/DIV, or drop a same-cycle start
//   busy       MULT/DIV in progress
//   done       one-cycle pulse: new HI/LO visible
//   hi, lo     architectural HI/LO registers
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 FINISH)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;   // quotient / product must be negated
  logic               neg_rem;   // remainder takes the sign of the dividend
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_orig;
  // Multiply: {partial product high, multiplier shifting out at bit 0}.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign dbg_state = state;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

    // The partial remainder is WIDTH+1 bits wide once shifted. Any subtraction
    // that does not borrow leaves a value below the divisor. That value fits
    // in WIDTH bits, so only the low bits of the difference are kept.
    div_shift = {rem, acc[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, mag_b});
    div_sub   = div_shift[WIDTH-1:0] - mag_b;

    prod_fix  = neg_res ? -acc : acc;
    quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_orig   <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                mag_a    <= abs_a;
                mag_b    <= abs_b;
                a_orig   <= a;
                is_div   <= op[1];
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
                acc      <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                rem      <= '0;
                count    <= '0;
                busy     <= 1'b1;
                state    <= S_RUN;
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              rem              <= div_ok ? div_sub : div_shift[WIDTH-1:0];
              acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ok};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) state <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
